// File: rtl/alu_nibble_sequencer.sv
// Runs one W-bit operation through an external 4-bit combinational ALU, one nibble per
// cycle (LSB first), chaining carry/borrow and registering the wide result and flags.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic                 req_cin,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_opcode,
    output logic                 alu_cin,
    input  logic [3:0]           alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_result,
    output logic                 rsp_cout,
    output logic                 rsp_zero,
    output logic                 rsp_negative,
    output logic                 rsp_overflow
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [IDXW-1:0]   idx;
    logic [2:0]        op_q;
    logic [W-1:0]      a_q, b_q, acc;
    logic              cin_q, carry_q;

    logic              last_nibble, is_arith, chain_cin;
    logic [IDXW+1:0]   nib_shift;
    logic [3:0]        res_nib;
    logic [W-1:0]      nib_mask, acc_next, final_result;
    logic              final_cout, final_ovf;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid)   state_next = RUN;
            RUN:     if (last_nibble) state_next = DONE;
            DONE:    if (rsp_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SLT borrows the SUB datapath; only ADD/SUB take the client's carry-in on nibble 0.
    always_comb begin
        last_nibble  = (idx == IDXW'(NIBBLES - 1));
        is_arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
        nib_shift    = {idx, 2'b00};
        chain_cin    = (idx == '0) ? (is_arith & cin_q) : carry_q;

        alu_a      = 4'h0;
        alu_b      = 4'h0;
        alu_opcode = 3'b000;
        alu_cin    = 1'b0;
        if (state == RUN) begin
            alu_a      = 4'(a_q >> nib_shift);
            alu_b      = 4'(b_q >> nib_shift);
            alu_opcode = (op_q == OP_SLT) ? OP_SUB : op_q;
            alu_cin    = (is_arith || op_q == OP_SLT) ? chain_cin : 1'b0;
        end

        res_nib      = alu_result | {3'b000, (op_q == OP_SLL) & carry_q};
        nib_mask     = W'(4'hF) << nib_shift;
        acc_next     = (acc & ~nib_mask) | (W'(res_nib) << nib_shift);
        final_result = (op_q == OP_SLT) ? W'(alu_cout) : acc_next;
        final_cout   = (is_arith || op_q == OP_SLL) & alu_cout;
        final_ovf    = is_arith & alu_overflow;
    end

    // Response registers only change on the final nibble, so they hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            op_q         <= 3'b000;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            acc          <= '0;
            carry_q      <= 1'b0;
            rsp_result   <= '0;
            rsp_cout     <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q    <= req_op;
                a_q     <= req_a;
                b_q     <= req_b;
                cin_q   <= req_cin;
                idx     <= '0;
                acc     <= '0;
                carry_q <= 1'b0;
            end
            if (state == RUN) begin
                acc     <= acc_next;
                carry_q <= alu_cout;
                if (last_nibble) begin
                    idx          <= '0;
                    rsp_result   <= final_result;
                    rsp_cout     <= final_cout;
                    rsp_zero     <= (final_result == '0);
                    rsp_negative <= final_result[W-1];
                    rsp_overflow <= final_ovf;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a behavioural 4-bit ALU closes the loop, and directed
// operations are checked against hand-computed 16-bit results and flags.
module tb_alu_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_cin;
    logic [2:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [3:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic        alu_cin, alu_cout, alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_cout, rsp_zero, rsp_negative, rsp_overflow;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          last_latency;
    logic [3:0]  cin_seq;
    logic [11:0] op_seq;

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
        .rsp_overflow(rsp_overflow)
    );

    always #5 clk = ~clk;

    // Reference 4-bit ALU; SUB reports borrow on cout.
    always_comb begin
        logic [4:0] wide;
        wide         = 5'd0;
        alu_result   = 4'h0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_opcode)
            3'b000: begin
                wide         = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                alu_result   = wide[3:0];
                alu_cout     = wide[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (wide[3] != alu_a[3]);
            end
            3'b001: begin
                wide         = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
                alu_result   = wide[3:0];
                alu_cout     = wide[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (wide[3] != alu_a[3]);
            end
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = ~alu_a;
            3'b110: alu_result = {3'b000, alu_a < alu_b};
            3'b111: begin
                alu_result = {alu_a[2:0], 1'b0};
                alu_cout   = alu_a[3];
            end
            default: alu_result = 4'h0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for the response, logging alu_cin/alu_opcode per RUN cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        int cycles;
        checkOutput("req_ready_before_request", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        tick();
        req_valid = 1'b0;
        checkOutput("req_ready_after_accept", req_ready, 0);
        cycles  = 0;
        cin_seq = 4'h0;
        op_seq  = 12'h000;
        while (!rsp_valid && cycles < 20) begin
            if (cycles < 4) begin
                cin_seq[cycles]        = alu_cin;
                op_seq[3*cycles +: 3]  = alu_opcode;
            end
            cycles++;
            tick();
        end
        last_latency = cycles + 1;
        checkOutput("response_arrived", rsp_valid, 1);
    endtask

    task automatic checkResponse(input string name, input logic [15:0] result, input logic cout,
                                 input logic zero, input logic neg, input logic ovf);
        checkOutput({name, "_latency"},  last_latency, 5);
        checkOutput({name, "_result"},   rsp_result, result);
        checkOutput({name, "_cout"},     rsp_cout, cout);
        checkOutput({name, "_zero"},     rsp_zero, zero);
        checkOutput({name, "_negative"}, rsp_negative, neg);
        checkOutput({name, "_overflow"}, rsp_overflow, ovf);
    endtask

    task automatic finishResponse();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_a = 16'h0; req_b = 16'h0;
        req_cin = 1'b0; rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_result", rsp_result, 16'h0000);
        checkOutput("reset_rsp_flags", {rsp_cout, rsp_zero, rsp_negative, rsp_overflow}, 4'b0000);
        checkOutput("reset_alu_bus", {alu_a, alu_b, alu_opcode, alu_cin}, 12'h000);

        applyStimulus(3'b000, 16'hFFFF, 16'h0001, 1'b0);
        checkResponse("add_wrap", 16'h0000, 1, 1, 0, 0);
        checkOutput("add_wrap_cin_seq", cin_seq, 4'b1110);
        finishResponse();

        applyStimulus(3'b000, 16'h7FFF, 16'h0000, 1'b1);
        checkResponse("add_cin_ovf", 16'h8000, 0, 0, 1, 1);
        finishResponse();

        applyStimulus(3'b001, 16'h8000, 16'h0001, 1'b0);
        checkResponse("sub_ovf", 16'h7FFF, 0, 0, 0, 1);
        checkOutput("sub_ovf_cin_seq", cin_seq, 4'b1110);
        finishResponse();

        applyStimulus(3'b001, 16'h0005, 16'h0003, 1'b1);
        checkResponse("sub_bin", 16'h0001, 0, 0, 0, 0);
        checkOutput("sub_bin_cin_seq", cin_seq, 4'b0001);
        finishResponse();

        applyStimulus(3'b110, 16'h0003, 16'h1000, 1'b1);
        checkResponse("slt_true", 16'h0001, 0, 0, 0, 0);
        checkOutput("slt_true_opcodes", op_seq, 12'h249);
        checkOutput("slt_true_cin_seq", cin_seq, 4'b0000);
        finishResponse();

        applyStimulus(3'b110, 16'h1000, 16'h0003, 1'b0);
        checkResponse("slt_false", 16'h0000, 0, 1, 0, 0);
        checkOutput("slt_false_opcodes", op_seq, 12'h249);
        finishResponse();

        applyStimulus(3'b111, 16'h8421, 16'h0000, 1'b0);
        checkResponse("sll", 16'h0842, 1, 0, 0, 0);
        checkOutput("sll_cin_seq", cin_seq, 4'b0000);
        finishResponse();

        applyStimulus(3'b100, 16'hF0F0, 16'hFFFF, 1'b1);
        checkResponse("xor", 16'h0F0F, 0, 0, 0, 0);
        checkOutput("xor_cin_seq", cin_seq, 4'b0000);
        finishResponse();

        applyStimulus(3'b101, 16'h00FF, 16'h1234, 1'b0);
        checkResponse("not", 16'hFF00, 0, 0, 1, 0);
        finishResponse();

        applyStimulus(3'b010, 16'h1234, 16'h00FF, 1'b0);
        checkResponse("and", 16'h0034, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_rsp_valid", rsp_valid, 1);
            checkOutput("bp_rsp_result", rsp_result, 16'h0034);
            checkOutput("bp_req_ready", req_ready, 0);
            tick();
        end
        finishResponse();
        checkOutput("release_rsp_valid", rsp_valid, 0);
        checkOutput("release_req_ready", req_ready, 1);
        checkOutput("release_result_held", rsp_result, 16'h0034);

        applyStimulus(3'b011, 16'h00F0, 16'h0F00, 1'b0);
        checkResponse("or_back_to_back", 16'h0FF0, 0, 0, 0, 0);
        finishResponse();

        req_valid = 1'b1; req_op = 3'b000; req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checkOutput("midrun_alu_a_idx2", alu_a, 4'h1);
        checkOutput("midrun_alu_b_idx2", alu_b, 4'h2);
        rst = 1'b1;
        tick();
        checkOutput("abort_rsp_valid", rsp_valid, 0);
        checkOutput("abort_alu_bus", {alu_a, alu_b, alu_opcode, alu_cin}, 12'h000);
        checkOutput("abort_req_ready", req_ready, 1);
        checkOutput("abort_rsp_result", rsp_result, 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("abort_no_response", rsp_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
